// File: rtl/lock_attempt_guard_pkg.sv
// Shared definitions for the lock attempt guard: FSM state encoding and timer width.
package lock_attempt_guard_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/lock_attempt_guard_flasher.sv
// Alarm LED divider: toggles every half_period cycles while en is high, held cleared otherwise.
module lock_flasher
  import lock_attempt_guard_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] half_period,
  output logic             led
);

  logic [TMR_W-1:0] cnt_q;

  // A cleared counter toggles on the first enabled edge, so the LED turns on immediately.
  always_ff @(posedge clk) begin
    if (clr || !en) begin
      cnt_q <= '0;
      led   <= 1'b0;
    end else if (cnt_q == '0) begin
      led   <= ~led;
      cnt_q <= half_period - TMR_W'(1);
    end else begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

endmodule

// File: rtl/lock_attempt_guard.sv
// Lock attempt guard: opens the lock on a matching entry, counts consecutive misses and enforces a timed lockout.
module lock_attempt_guard
  import lock_attempt_guard_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 500,
  parameter int FLASH_HALF     = 25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       judge_en,
  input  logic       judge_match,
  output logic       unlock,
  output logic       lockout,
  output logic       led,
  output logic [3:0] fail_count
);

  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] FLASH_HALF_W = TMR_W'(FLASH_HALF);
  localparam logic [3:0]       FAIL_MAX    = 4'(MAX_FAILS);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       fail_d, fail_inc;
  logic             unlock_d, lockout_d;
  logic             en_q, eval;

  assign eval     = judge_en & ~en_q;
  assign fail_inc = fail_count + 4'd1;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = ST_IDLE;
    timer_d   = timer_q;
    fail_d    = fail_count;
    unlock_d  = 1'b0;
    lockout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eval && judge_match) begin
          state_d  = ST_OPEN;
          unlock_d = 1'b1;
          timer_d  = UNLOCK_LOAD;
          fail_d   = '0;
        end else if (eval) begin
          fail_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d   = ST_LOCKED;
            lockout_d = 1'b1;
            timer_d   = LOCK_LOAD;
          end
        end
      end
      ST_OPEN: begin
        if (timer_q != '0) begin
          state_d  = ST_OPEN;
          unlock_d = 1'b1;
          timer_d  = timer_q - TMR_W'(1);
        end
      end
      ST_LOCKED: begin
        if (timer_q != '0) begin
          state_d   = ST_LOCKED;
          lockout_d = 1'b1;
          timer_d   = timer_q - TMR_W'(1);
        end else begin
          fail_d = '0;
        end
      end
      default: begin
        // Unused encoding: fall back to IDLE with everything cleared.
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      timer_q    <= '0;
      fail_count <= '0;
      unlock     <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= judge_en;
      timer_q    <= timer_d;
      fail_count <= fail_d;
      unlock     <= unlock_d;
      lockout    <= lockout_d;
    end
  end

  // Enabled from the next state so the LED lights on the same edge lockout rises and clears as it falls.
  lock_flasher u_flasher (
    .clk         (clk),
    .clr         (clr),
    .en          (state_d == ST_LOCKED),
    .half_period (FLASH_HALF_W),
    .led         (led)
  );

endmodule

// File: tb/tb_lock_attempt_guard.sv
// Scoreboard bench for lock_attempt_guard: a window-based reference model predicts every cycle's outputs.
module tb_lock_attempt_guard;

  localparam int MAXF = 3;
  localparam int UNL  = 4;
  localparam int LCK  = 20;
  localparam int HALF = 2;

  logic       clk = 1'b0;
  logic       clr, judge_en, judge_match;
  logic       unlock, lockout, led;
  logic [3:0] fail_count;

  always #5 clk = ~clk;

  lock_attempt_guard #(
    .MAX_FAILS      (MAXF),
    .UNLOCK_CYCLES  (UNL),
    .LOCKOUT_CYCLES (LCK),
    .FLASH_HALF     (HALF)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .judge_en    (judge_en),
    .judge_match (judge_match),
    .unlock      (unlock),
    .lockout     (lockout),
    .led         (led),
    .fail_count  (fail_count)
  );

  typedef struct packed {
    logic       unlock;
    logic       lockout;
    logic       led;
    logic [3:0] fails;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: absolute edge indices of the open/lockout windows rather than timers.
  int   cyc        = 0;
  int   open_end   = -10;
  int   lock_start = -10;
  int   lock_end   = -10;
  int   fails      = 0;
  logic prev_en    = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic step(input logic c, input logic e, input logic m);
    exp_t x;
    logic ev, idle;
    @(negedge clk);
    clr = c; judge_en = e; judge_match = m;
    cyc++;
    if (c) begin
      open_end = cyc; lock_end = cyc; fails = 0; prev_en = 1'b0;
    end else begin
      ev      = e && !prev_en;
      prev_en = e;
      idle    = (cyc > open_end) && (cyc > lock_end);
      if (idle && ev) begin
        if (m) begin
          open_end = cyc + UNL;
          fails    = 0;
        end else begin
          fails++;
          if (fails == MAXF) begin
            lock_start = cyc;
            lock_end   = cyc + LCK;
          end
        end
      end
      if (cyc == lock_end) fails = 0;
    end
    x.unlock  = cyc < open_end;
    x.lockout = cyc < lock_end;
    x.led     = (cyc < lock_end) && ((((cyc - lock_start) / HALF) % 2) == 0);
    x.fails   = 4'(fails);
    sb.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("unlock",     {3'b0, unlock},  {3'b0, x.unlock});
        check("lockout",    {3'b0, lockout}, {3'b0, x.lockout});
        check("led",        {3'b0, led},     {3'b0, x.led});
        check("fail_count", fail_count,      x.fails);
      end
    end
  end

  initial begin
    clr = 1'b1; judge_en = 1'b0; judge_match = 1'b0;
    repeat (2) step(1, 0, 0);

    // Single accepted match.
    step(0, 1, 1);
    repeat (6) step(0, 0, 0);

    // Held mismatch: one evaluation only.
    repeat (10) step(0, 1, 0);
    repeat (2) step(0, 0, 0);

    // Three mismatch edges into lockout, with ignored entries during it.
    step(1, 0, 0);
    repeat (3) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    for (int i = 0; i < 24; i++) step(0, (i % 3) == 0, 1'(i % 2));

    // Entries during OPEN, including at the expiry edge.
    step(0, 1, 1); step(0, 0, 0); step(0, 1, 1); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // Two misses, match clears, one more miss.
    step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 1);
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    repeat (2) step(0, 0, 0);

    // Clear mid-lockout, then clear mid-open, then a normal open.
    step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 1);
    repeat (6) step(0, 0, 0);

    // Randomized traffic.
    repeat (1500)
      step($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    step(0, 0, 0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 4'(sb.size()), 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
